// File: rtl/aes_frame_receiver_if.sv
// Byte-stream and AES-core signal bundle for the frame receiver.
// The receiver connects through the slave modport; the driver of the SPI/core side uses master.
interface aes_frame_receiver_if #(
  parameter int MAX_KEY_BYTES = 32
);
  logic                       rx_valid;
  logic [7:0]                 rx_data;
  logic                       cs_n;
  logic                       core_done;
  logic [127:0]               core_result;
  logic [127:0]               text_out;
  logic [8*MAX_KEY_BYTES-1:0] key_out;
  logic [7:0]                 key_size_out;
  logic                       core_start;
  logic [7:0]                 tx_data;
  logic                       busy;
  logic                       frame_err;

  modport slave (
    input  rx_valid, rx_data, cs_n, core_done, core_result,
    output text_out, key_out, key_size_out, core_start, tx_data, busy, frame_err
  );

  modport master (
    output rx_valid, rx_data, cs_n, core_done, core_result,
    input  text_out, key_out, key_size_out, core_start, tx_data, busy, frame_err
  );
endinterface

// File: rtl/aes_frame_receiver.sv
// Parses text/key-size/key frames from the SPI slave into AES core inputs,
// starts the core, and streams the 128-bit result back one byte per master transfer.
module aes_frame_receiver #(
  parameter int TEXT_BYTES    = 16,
  parameter int MAX_KEY_BYTES = 32
) (
  input  logic               clk,
  input  logic               reset,
  aes_frame_receiver_if.slave bus
);

  localparam int          TEXT_W    = 8 * TEXT_BYTES;
  localparam int          KEY_W     = 8 * MAX_KEY_BYTES;
  localparam logic [5:0]  LAST_BYTE = 6'(TEXT_BYTES - 1);

  typedef enum logic [2:0] {
    RX_TEXT,
    RX_SIZE,
    RX_KEY,
    START,
    WAIT_CORE,
    TX,
    ERR
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [TEXT_W-1:0] text_q, text_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [7:0]        size_q, size_d;
  logic [TEXT_W-1:0] result_q, result_d;
  logic [7:0]        tx_q, tx_d;
  logic              err_q, err_d;

  // NOTE: the text/key/result datapath is reset along with the control state,
  // since every output must read its defined value while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RX_TEXT;
      cnt_q    <= '0;
      text_q   <= '0;
      key_q    <= '0;
      size_q   <= 8'd32;
      result_q <= '0;
      tx_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      text_q   <= text_d;
      key_q    <= key_d;
      size_q   <= size_d;
      result_q <= result_d;
      tx_q     <= tx_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value gets a default first so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    text_d   = text_q;
    key_d    = key_q;
    size_d   = size_q;
    result_d = result_q;
    tx_d     = 8'h00;
    err_d    = err_q;

    unique case (state_q)
      RX_TEXT: begin
        // A byte arriving while chip select is released is discarded.
        if (bus.cs_n) begin
          cnt_d = '0;
        end else if (bus.rx_valid) begin
          text_d = {text_q[TEXT_W-9:0], bus.rx_data};
          if (cnt_q == 6'd0) begin
            err_d = 1'b0;
            key_d = '0;
          end
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = RX_SIZE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      RX_SIZE: begin
        if (bus.cs_n) begin
          cnt_d   = '0;
          state_d = RX_TEXT;
        end else if (bus.rx_valid) begin
          if (bus.rx_data == 8'd16 || bus.rx_data == 8'd24 || bus.rx_data == 8'd32) begin
            size_d  = bus.rx_data;
            cnt_d   = bus.rx_data[5:0];
            state_d = RX_KEY;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end

      RX_KEY: begin
        if (bus.cs_n) begin
          cnt_d   = '0;
          state_d = RX_TEXT;
        end else if (bus.rx_valid) begin
          // Key is right-aligned: byte written at count n lands in bits [8n-1 -: 8].
          for (int i = 0; i < MAX_KEY_BYTES; i++) begin
            if (cnt_q == 6'(i + 1)) key_d[8*i +: 8] = bus.rx_data;
          end
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = START;
        end
      end

      START: begin
        state_d = WAIT_CORE;
      end

      WAIT_CORE: begin
        if (bus.core_done) begin
          result_d = bus.core_result;
          tx_d     = bus.core_result[127:120];
          cnt_d    = '0;
          state_d  = TX;
        end
      end

      TX: begin
        if (bus.cs_n) begin
          cnt_d   = '0;
          state_d = RX_TEXT;
        end else begin
          tx_d = tx_q;
          if (bus.rx_valid) begin
            result_d = result_q << 8;
            if (cnt_q == LAST_BYTE) begin
              tx_d    = 8'h00;
              cnt_d   = '0;
              state_d = RX_TEXT;
            end else begin
              tx_d  = result_q[TEXT_W-9 -: 8];
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
      end

      ERR: begin
        if (bus.cs_n) begin
          cnt_d   = '0;
          state_d = RX_TEXT;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = RX_TEXT;
      end
    endcase
  end

  assign bus.text_out     = text_q;
  assign bus.key_out      = key_q;
  assign bus.key_size_out = size_q;
  assign bus.core_start   = (state_q == START);
  assign bus.tx_data      = tx_q;
  assign bus.busy         = !(state_q == RX_TEXT && cnt_q == 6'd0);
  assign bus.frame_err    = err_q;

endmodule

// File: tb/tb_aes_frame_receiver.sv
// Directed bench for aes_frame_receiver: full frames of each key size, bad size,
// key-phase abort, WAIT_CORE filtering and asynchronous reset in TX.
module tb_aes_frame_receiver;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   start_count = 0;

  aes_frame_receiver_if bus ();

  aes_frame_receiver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (bus.core_start === 1'b1) start_count++;

  // Inputs are driven just after a falling edge; outputs are checked at falling edges.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_text(input logic [127:0] t);
    for (int i = 0; i < 16; i++) send_byte(t[127-8*i -: 8]);
  endtask

  task automatic send_key(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) send_byte(8'(base + i));
  endtask

  task automatic pulse_done(input logic [127:0] r);
    bus.core_done   = 1'b1;
    bus.core_result = r;
    @(negedge clk);
    bus.core_done   = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (bus.text_out !== 128'h0) begin failures++; $display("FAIL reset_text got=%h exp=0", bus.text_out); end
    checks++; if (bus.key_out !== 256'h0) begin failures++; $display("FAIL reset_key got=%h exp=0", bus.key_out); end
    checks++; if (bus.key_size_out !== 8'd32) begin failures++; $display("FAIL reset_key_size got=%0d exp=32", bus.key_size_out); end
    checks++; if (bus.core_start !== 1'b0) begin failures++; $display("FAIL reset_core_start got=%b exp=0", bus.core_start); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx got=%h exp=00", bus.tx_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
  endtask

  task automatic test_aes256;
    logic [127:0] res;
    int           s0;
    res = 128'h8ea2b7ca516745bfeafc49904b496089;
    s0  = start_count;
    bus.cs_n = 1'b0;
    send_byte(8'h00);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL a256_busy_first got=%b exp=1", bus.busy); end
    for (int i = 1; i < 16; i++) send_byte(8'(i * 8'h11));
    send_byte(8'h20);
    send_key(32, 8'h00);
    checks++; if (bus.core_start !== 1'b1) begin failures++; $display("FAIL a256_core_start got=%b exp=1", bus.core_start); end
    checks++; if (bus.text_out !== 128'h00112233445566778899aabbccddeeff) begin failures++; $display("FAIL a256_text got=%h", bus.text_out); end
    checks++; if (bus.key_out !== 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f) begin failures++; $display("FAIL a256_key got=%h", bus.key_out); end
    checks++; if (bus.key_size_out !== 8'd32) begin failures++; $display("FAIL a256_key_size got=%0d exp=32", bus.key_size_out); end
    @(negedge clk);
    checks++; if (bus.core_start !== 1'b0) begin failures++; $display("FAIL a256_start_len got=%b exp=0", bus.core_start); end
    checks++; if (start_count - s0 !== 1) begin failures++; $display("FAIL a256_start_count got=%0d exp=1", start_count - s0); end
    pulse_done(res);
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.tx_data !== res[127-8*i -: 8]) begin failures++; $display("FAIL a256_tx_byte%0d got=%h exp=%h", i, bus.tx_data, res[127-8*i -: 8]); end
      send_byte(8'hff);
    end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL a256_tx_end got=%h exp=00", bus.tx_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL a256_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_aes128;
    send_text(128'h3243f6a8885a308d313198a2e0370734);
    send_byte(8'h10);
    send_key(15, 8'h00);
    checks++; if (bus.core_start !== 1'b0) begin failures++; $display("FAIL a128_early_start got=%b exp=0", bus.core_start); end
    send_byte(8'h0f);
    checks++; if (bus.core_start !== 1'b1) begin failures++; $display("FAIL a128_start_33 got=%b exp=1", bus.core_start); end
    checks++; if (bus.key_out !== {128'h0, 128'h000102030405060708090a0b0c0d0e0f}) begin failures++; $display("FAIL a128_key got=%h", bus.key_out); end
    checks++; if (bus.key_size_out !== 8'd16) begin failures++; $display("FAIL a128_key_size got=%0d exp=16", bus.key_size_out); end
    checks++; if (bus.text_out !== 128'h3243f6a8885a308d313198a2e0370734) begin failures++; $display("FAIL a128_text got=%h", bus.text_out); end
    @(negedge clk);
    pulse_done(128'h3925841d02dc09fbdc118597196a0b32);
    checks++; if (bus.tx_data !== 8'h39) begin failures++; $display("FAIL a128_tx0 got=%h exp=39", bus.tx_data); end
    send_key(3, 8'h00);
    checks++; if (bus.tx_data !== 8'h1d) begin failures++; $display("FAIL a128_tx3 got=%h exp=1d", bus.tx_data); end
    // Abort mid-TX: back to idle, tx cleared, text kept.
    bus.cs_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL a128_abort_tx got=%h exp=00", bus.tx_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL a128_abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.text_out !== 128'h3243f6a8885a308d313198a2e0370734) begin failures++; $display("FAIL a128_abort_text got=%h", bus.text_out); end
    bus.cs_n = 1'b0;
  endtask

  task automatic test_bad_size;
    int s0;
    s0 = start_count;
    send_text(128'h0f0e0d0c0b0a09080706050403020100);
    send_byte(8'h11);
    checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL bad_err_set got=%b exp=1", bus.frame_err); end
    send_byte(8'h10);
    send_key(4, 8'h00);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL bad_hold_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.key_size_out !== 8'd16) begin failures++; $display("FAIL bad_key_size got=%0d exp=16", bus.key_size_out); end
    bus.cs_n = 1'b1;
    @(negedge clk);
    bus.cs_n = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL bad_release_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.frame_err !== 1'b1) begin failures++; $display("FAIL bad_err_sticky got=%b exp=1", bus.frame_err); end
    checks++; if (start_count - s0 !== 0) begin failures++; $display("FAIL bad_no_start got=%0d exp=0", start_count - s0); end
    send_byte(8'haa);
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL bad_err_clear got=%b exp=0", bus.frame_err); end
    checks++; if (bus.key_out !== 256'h0) begin failures++; $display("FAIL bad_key_zeroed got=%h exp=0", bus.key_out); end
    for (int i = 1; i < 16; i++) send_byte(8'haa);
    send_byte(8'h10);
    send_key(16, 8'h80);
    checks++; if (bus.key_out !== {128'h0, 128'h808182838485868788898a8b8c8d8e8f}) begin failures++; $display("FAIL bad_next_key got=%h", bus.key_out); end
    @(negedge clk);
    pulse_done(128'h0);
    send_key(16, 8'h00);
    checks++; if (start_count - s0 !== 1) begin failures++; $display("FAIL bad_next_start got=%0d exp=1", start_count - s0); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL bad_next_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_abort_key;
    int s0;
    s0 = start_count;
    send_text(128'h11111111111111111111111111111111);
    send_byte(8'h18);
    send_key(5, 8'h00);
    bus.cs_n = 1'b1;
    @(negedge clk);
    bus.cs_n = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.key_out !== {64'h0, 40'h0001020304, 152'h0}) begin failures++; $display("FAIL abort_key_kept got=%h", bus.key_out); end
    @(negedge clk);
    checks++; if (start_count - s0 !== 0) begin failures++; $display("FAIL abort_no_start got=%0d exp=0", start_count - s0); end
    send_text(128'hffeeddccbbaa99887766554433221100);
    send_byte(8'h18);
    send_key(24, 8'h40);
    checks++; if (bus.core_start !== 1'b1) begin failures++; $display("FAIL a192_start got=%b exp=1", bus.core_start); end
    checks++; if (bus.key_out !== {64'h0, 192'h404142434445464748494a4b4c4d4e4f5051525354555657}) begin failures++; $display("FAIL a192_key got=%h", bus.key_out); end
    checks++; if (bus.key_size_out !== 8'd24) begin failures++; $display("FAIL a192_key_size got=%0d exp=24", bus.key_size_out); end
    checks++; if (bus.text_out !== 128'hffeeddccbbaa99887766554433221100) begin failures++; $display("FAIL a192_text got=%h", bus.text_out); end
  endtask

  // Entered with core_start high (START state) from the AES-192 frame.
  task automatic test_wait_core;
    logic [127:0] r2;
    r2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    pulse_done(128'hdeadbeefdeadbeefdeadbeefdeadbeef);
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL wait_done_at_start got=%h exp=00", bus.tx_data); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL wait_busy got=%b exp=1", bus.busy); end
    send_key(3, 8'h55);
    bus.cs_n = 1'b1;
    @(negedge clk);
    bus.cs_n = 1'b0;
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL wait_rx_ignored got=%h exp=00", bus.tx_data); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL wait_cs_ignored got=%b exp=1", bus.busy); end
    pulse_done(r2);
    checks++; if (bus.tx_data !== 8'hdd) begin failures++; $display("FAIL wait_late_done got=%h exp=dd", bus.tx_data); end
    send_key(5, 8'h00);
    checks++; if (bus.tx_data !== r2[127-8*5 -: 8]) begin failures++; $display("FAIL wait_tx5 got=%h exp=%h", bus.tx_data, r2[127-8*5 -: 8]); end
  endtask

  // Entered in TX mid-result; reset is raised between clock edges.
  task automatic test_async_reset;
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL areset_tx got=%h exp=00", bus.tx_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.text_out !== 128'h0) begin failures++; $display("FAIL areset_text got=%h exp=0", bus.text_out); end
    checks++; if (bus.key_out !== 256'h0) begin failures++; $display("FAIL areset_key got=%h exp=0", bus.key_out); end
    checks++; if (bus.key_size_out !== 8'd32) begin failures++; $display("FAIL areset_key_size got=%0d exp=32", bus.key_size_out); end
    checks++; if (bus.core_start !== 1'b0) begin failures++; $display("FAIL areset_start got=%b exp=0", bus.core_start); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL areset_after got=%b exp=0", bus.busy); end
  endtask

  initial begin
    reset           = 1'b1;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.cs_n        = 1'b1;
    bus.core_done   = 1'b0;
    bus.core_result = 128'h0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_aes256();
    test_aes128();
    test_bad_size();
    test_abort_key();
    test_wait_core();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
